// File: rtl/video_size_pkg.sv
`default_nettype none
// =============================================================================
// Module : video_size_pkg
// Desc   : Panel ID table, scale modes and FSM states for video_size_ctrl.
// Rev    : 1.0  initial release
// =============================================================================
package video_size_pkg;

    localparam logic [15:0] ID_4342 = 16'h4342;
    localparam logic [15:0] ID_7084 = 16'h7084;
    localparam logic [15:0] ID_7016 = 16'h7016;
    localparam logic [15:0] ID_1018 = 16'h1018;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic [15:0] hts;
        logic [15:0] vts;
    } mode_cfg_t;

    localparam mode_cfg_t CFG_480X272  = '{h: 16'd480,  v: 16'd272, hts: 16'd1800, vts: 16'd1000};
    localparam mode_cfg_t CFG_800X480  = '{h: 16'd800,  v: 16'd480, hts: 16'd1800, vts: 16'd1000};
    localparam mode_cfg_t CFG_1024X600 = '{h: 16'd1024, v: 16'd600, hts: 16'd2200, vts: 16'd1000};
    localparam mode_cfg_t CFG_1280X800 = '{h: 16'd1280, v: 16'd800, hts: 16'd2570, vts: 16'd980};
    localparam mode_cfg_t CFG_DEFAULT  = CFG_800X480;

    typedef enum logic [1:0] {
        SCALE_FULL        = 2'd0,
        SCALE_HALF        = 2'd1,
        SCALE_QUARTER     = 2'd2,
        SCALE_QUARTER_ALT = 2'd3
    } scale_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_MUL     = 3'd2,
        ST_WAIT_FS = 3'd3,
        ST_PUB     = 3'd4
    } state_e;

    function automatic mode_cfg_t lookup_mode(input logic [15:0] id);
        case (id)
            ID_4342: return CFG_480X272;
            ID_7084: return CFG_800X480;
            ID_7016: return CFG_1024X600;
            ID_1018: return CFG_1280X800;
            default: return CFG_DEFAULT;
        endcase
    endfunction

    // Mode 3 is reserved and behaves as quarter scale.
    function automatic logic [1:0] scale_shift(input logic [1:0] mode);
        case (scale_mode_e'(mode))
            SCALE_FULL: return 2'd0;
            SCALE_HALF: return 2'd1;
            default:    return 2'd2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_size_mult.sv
`default_nettype none
// =============================================================================
// Module : video_size_mult
// Desc   : Sequential shift-add PIX_W x PIX_W multiplier, saturating to ADDR_W.
// Rev    : 1.0  initial release
// =============================================================================
module video_size_mult
    import video_size_pkg::*;
#(
    parameter int PIX_W  = 13,
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [PIX_W-1:0]  mcand_i,
    input  logic [PIX_W-1:0]  mplier_i,
    output logic              done_o,
    output logic [ADDR_W-1:0] prod_o
);

    localparam int PROD_W = 2 * PIX_W;
    localparam int CNT_W  = $clog2(PIX_W + 1);

    logic [PROD_W-1:0] mcand_q;
    logic [PIX_W-1:0]  mplier_q;
    logic [PROD_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;
    logic [PROD_W-1:0] term_d;
    logic [PROD_W-1:0] sum_d;

    assign term_d = mplier_q[0] ? mcand_q : '0;
    assign sum_d  = acc_q + term_d;
    // Done is flagged during the final bit so the caller can capture sum_d on that edge.
    assign done_o = run_q && (cnt_q == CNT_W'(PIX_W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= PROD_W'(mcand_i);
            mplier_q <= mplier_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= sum_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

    generate
        if (PROD_W > ADDR_W) begin : g_sat
            assign prod_o = (|sum_d[PROD_W-1:ADDR_W]) ? '1 : sum_d[ADDR_W-1:0];
        end else begin : g_nosat
            assign prod_o = ADDR_W'(sum_d);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/video_size_ctrl.sv
`default_nettype none
// =============================================================================
// Module : video_size_ctrl
// Desc   : Debounced panel-ID/scale lookup publishing window, HTS/VTS and
//          SDRAM frame size through a valid/ready handshake.
// Option : VIDEO_SIZE_FRAME_SYNC_EN aligns each publish to a frame_start pulse.
// Rev    : 1.0  initial release
// =============================================================================
module video_size_ctrl
    import video_size_pkg::*;
#(
    parameter int PIX_W      = 13,
    parameter int ADDR_W     = 24,
    parameter int STABLE_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       ID_lcd,
    input  logic [1:0]        scale_mode,
    input  logic              cfg_ready,
`ifdef VIDEO_SIZE_FRAME_SYNC_EN
    input  logic              frame_start,
`endif
    output logic [PIX_W-1:0]  cmos_h_pixel,
    output logic [PIX_W-1:0]  cmos_v_pixel,
    output logic [PIX_W-1:0]  total_h_pixel,
    output logic [PIX_W-1:0]  total_v_pixel,
    output logic [ADDR_W-1:0] sdram_max_addr,
    output logic              cfg_valid,
    output logic              busy
);

    localparam int KEY_W = 18;
    localparam int CNT_W = $clog2(STABLE_CYC);

    logic [KEY_W-1:0]  key_d;
    logic [KEY_W-1:0]  cand_q;
    logic              cand_vld_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              key_chg_d;
    logic              stable_d;

    assign key_d     = {ID_lcd, scale_mode};
    assign key_chg_d = !cand_vld_q || (key_d != cand_q);
    assign stable_d  = (cnt_q == CNT_W'(STABLE_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else if (key_chg_d) begin
            cand_q     <= key_d;
            cand_vld_q <= 1'b1;
            cnt_q      <= '0;
        end else if (!stable_d) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    mode_cfg_t        cfg_d;
    logic [1:0]       shift_d;
    logic [PIX_W-1:0] h_d, v_d, hts_d, vts_d;

    assign cfg_d   = lookup_mode(cand_q[KEY_W-1:2]);
    assign shift_d = scale_shift(cand_q[1:0]);
    assign h_d     = PIX_W'(cfg_d.h >> shift_d);
    assign v_d     = PIX_W'(cfg_d.v >> shift_d);
    assign hts_d   = PIX_W'(cfg_d.hts);
    assign vts_d   = PIX_W'(cfg_d.vts);

    state_e            state_q;
    logic [PIX_W-1:0]  h_q, v_q, hts_q, vts_q;
    logic [KEY_W-1:0]  load_key_q;
    logic [KEY_W-1:0]  active_key_q;
    logic              active_vld_q;
    logic [PIX_W-1:0]  cmos_h_q, cmos_v_q, tot_h_q, tot_v_q;
    logic [ADDR_W-1:0] sdram_q;
    logic              cfg_valid_q;
    logic              busy_q;
    logic              mult_done;
    logic [ADDR_W-1:0] mult_prod;
`ifdef VIDEO_SIZE_FRAME_SYNC_EN
    logic [ADDR_W-1:0] prod_q;
`endif

    // Operands come straight from the lookup so the multiply overlaps the LOAD cycle's capture.
    video_size_mult #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_mult (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (state_q == ST_LOAD),
        .mcand_i  (h_d),
        .mplier_i (v_d),
        .done_o   (mult_done),
        .prod_o   (mult_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            h_q          <= '0;
            v_q          <= '0;
            hts_q        <= '0;
            vts_q        <= '0;
            load_key_q   <= '0;
            active_key_q <= '0;
            active_vld_q <= 1'b0;
            cmos_h_q     <= '0;
            cmos_v_q     <= '0;
            tot_h_q      <= '0;
            tot_v_q      <= '0;
            sdram_q      <= '0;
            cfg_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef VIDEO_SIZE_FRAME_SYNC_EN
            prod_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stable_d && !key_chg_d && (!active_vld_q || (cand_q != active_key_q))) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (key_chg_d) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        h_q        <= h_d;
                        v_q        <= v_d;
                        hts_q      <= hts_d;
                        vts_q      <= vts_d;
                        load_key_q <= cand_q;
                        state_q    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (key_chg_d) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (mult_done) begin
`ifdef VIDEO_SIZE_FRAME_SYNC_EN
                        prod_q  <= mult_prod;
                        state_q <= ST_WAIT_FS;
`else
                        cmos_h_q    <= h_q;
                        cmos_v_q    <= v_q;
                        tot_h_q     <= hts_q;
                        tot_v_q     <= vts_q;
                        sdram_q     <= mult_prod;
                        cfg_valid_q <= 1'b1;
                        state_q     <= ST_PUB;
`endif
                    end
                end
`ifdef VIDEO_SIZE_FRAME_SYNC_EN
                ST_WAIT_FS: begin
                    if (key_chg_d) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (frame_start) begin
                        cmos_h_q    <= h_q;
                        cmos_v_q    <= v_q;
                        tot_h_q     <= hts_q;
                        tot_v_q     <= vts_q;
                        sdram_q     <= prod_q;
                        cfg_valid_q <= 1'b1;
                        state_q     <= ST_PUB;
                    end
                end
`endif
                ST_PUB: begin
                    // The published key, not the live candidate, becomes active so a
                    // change seen during the handshake still triggers a fresh publish.
                    if (cfg_ready) begin
                        cfg_valid_q  <= 1'b0;
                        active_key_q <= load_key_q;
                        active_vld_q <= 1'b1;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmos_h_pixel   = cmos_h_q;
    assign cmos_v_pixel   = cmos_v_q;
    assign total_h_pixel  = tot_h_q;
    assign total_v_pixel  = tot_v_q;
    assign sdram_max_addr = sdram_q;
    assign cfg_valid      = cfg_valid_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_video_size_ctrl.sv
`default_nettype none
// =============================================================================
// Module : tb_video_size_ctrl
// Desc   : Directed plus randomized checks of video_size_ctrl against a table model.
// Rev    : 1.0  initial release
// =============================================================================
module tb_video_size_ctrl;

    localparam int PIX_W      = 13;
    localparam int ADDR_W     = 24;
    localparam int STABLE_CYC = 1024;
    // Edges counted from the first key sample up to and including the one raising cfg_valid.
    localparam int EXP_LAT    = STABLE_CYC + PIX_W + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       id;
    logic [1:0]        mode;
    logic              cfg_ready;
    logic [PIX_W-1:0]  cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel;
    logic [ADDR_W-1:0] sdram_max_addr;
    logic              cfg_valid;
    logic              busy;
`ifdef VIDEO_SIZE_FRAME_SYNC_EN
    logic              frame_start = 1'b0;
    logic              fs_at_edge  = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef VIDEO_SIZE_FRAME_SYNC_EN
    always @(negedge clk) frame_start = ($urandom_range(0, 19) == 0);
    always @(posedge clk) fs_at_edge <= frame_start;
`endif

    video_size_ctrl #(
        .PIX_W      (PIX_W),
        .ADDR_W     (ADDR_W),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ID_lcd         (id),
        .scale_mode     (mode),
        .cfg_ready      (cfg_ready),
`ifdef VIDEO_SIZE_FRAME_SYNC_EN
        .frame_start    (frame_start),
`endif
        .cmos_h_pixel   (cmos_h_pixel),
        .cmos_v_pixel   (cmos_v_pixel),
        .total_h_pixel  (total_h_pixel),
        .total_v_pixel  (total_v_pixel),
        .sdram_max_addr (sdram_max_addr),
        .cfg_valid      (cfg_valid),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: panel table, divide by the scale factor, multiply, clamp.
    function automatic void ref_cfg(input logic [15:0] rid, input logic [1:0] rmode,
                                    output int eh, output int ev, output int ehts,
                                    output int evts, output int eaddr);
        int div;
        case (rid)
            16'h4342: begin eh = 480;  ev = 272; ehts = 1800; evts = 1000; end
            16'h7084: begin eh = 800;  ev = 480; ehts = 1800; evts = 1000; end
            16'h7016: begin eh = 1024; ev = 600; ehts = 2200; evts = 1000; end
            16'h1018: begin eh = 1280; ev = 800; ehts = 2570; evts = 980;  end
            default:  begin eh = 800;  ev = 480; ehts = 1800; evts = 1000; end
        endcase
        div   = (rmode == 2'd0) ? 1 : (rmode == 2'd1) ? 2 : 4;
        eh    = eh / div;
        ev    = ev / div;
        eaddr = eh * ev;
        if (eaddr > (1 << ADDR_W) - 1) eaddr = (1 << ADDR_W) - 1;
    endfunction

    task automatic check_cfg(input string tag, input logic [15:0] rid, input logic [1:0] rmode);
        int eh, ev, ehts, evts, eaddr;
        ref_cfg(rid, rmode, eh, ev, ehts, evts, eaddr);
        chk({tag, ".h"},    32'(cmos_h_pixel),   eh);
        chk({tag, ".v"},    32'(cmos_v_pixel),   ev);
        chk({tag, ".hts"},  32'(total_h_pixel),  ehts);
        chk({tag, ".vts"},  32'(total_v_pixel),  evts);
        chk({tag, ".addr"}, 32'(sdram_max_addr), eaddr);
    endtask

    task automatic wait_valid(input string tag, input int budget, output int n);
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(posedge clk);
            #1;
            n++;
            if (cfg_valid === 1'b1) ok = 1'b1;
        end
        chk({tag, ".timeout"}, 32'(ok), 1);
`ifdef VIDEO_SIZE_FRAME_SYNC_EN
        if (ok) chk({tag, ".fs_align"}, 32'(fs_at_edge), 1);
`endif
    endtask

    task automatic chk_lat(input string tag, input int n);
`ifdef VIDEO_SIZE_FRAME_SYNC_EN
        chk({tag, ".lat_min"}, 32'(n >= EXP_LAT), 1);
`else
        chk({tag, ".lat"}, n, EXP_LAT);
`endif
    endtask

    task automatic apply_key(input logic [15:0] nid, input logic [1:0] nmode);
        @(negedge clk);
        id   = nid;
        mode = nmode;
    endtask

    task automatic publish(input string tag, input logic [15:0] nid, input logic [1:0] nmode);
        int n;
        apply_key(nid, nmode);
        wait_valid(tag, EXP_LAT + 300, n);
        chk_lat(tag, n);
        check_cfg(tag, nid, nmode);
    endtask

    initial begin
        int n;
        int seen_v, seen_b, bad;
        logic [15:0] rid;
        logic [1:0]  rmode;
        logic [PIX_W-1:0]  hold_h, hold_v;
        logic [ADDR_W-1:0] hold_a;

        rst_n     = 1'b0;
        id        = 16'h4342;
        mode      = 2'd0;
        cfg_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst.h",     32'(cmos_h_pixel),   0);
        chk("rst.v",     32'(cmos_v_pixel),   0);
        chk("rst.hts",   32'(total_h_pixel),  0);
        chk("rst.vts",   32'(total_v_pixel),  0);
        chk("rst.addr",  32'(sdram_max_addr), 0);
        chk("rst.valid", 32'(cfg_valid),      0);
        chk("rst.busy",  32'(busy),           0);

        // Test 1: first key sampled at the edge right after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("t1", EXP_LAT + 300, n);
        chk_lat("t1", n);
        check_cfg("t1", 16'h4342, 2'd0);
        chk("t1.busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        chk("t1.pulse", 32'(cfg_valid), 0);
        seen_v = 0;
        repeat (100) begin
            @(negedge clk);
            if (cfg_valid) seen_v++;
        end
        chk("t1.norepub", seen_v, 0);

        // Test 2: half scale.
        publish("t2", 16'h1018, 2'd1);

        // Randomized keys, always different from the current one.
        for (int i = 0; i < 3; i++) begin
            case ($urandom_range(0, 4))
                0: rid = 16'h4342;
                1: rid = 16'h7084;
                2: rid = 16'h7016;
                3: rid = 16'h1018;
                default: rid = 16'($urandom);
            endcase
            rmode = 2'($urandom_range(0, 3));
            if ({rid, rmode} == {id, mode} || {rid, rmode} == {16'h7084, 2'd0})
                rmode = rmode ^ 2'd1;
            if ({rid, rmode} == {id, mode}) rmode = rmode ^ 2'd2;
            publish($sformatf("rnd%0d", i), rid, rmode);
        end

        // Test 3: short glitch must not publish.
        publish("t3a", 16'h7084, 2'd0);
        apply_key(16'h7016, 2'd0);
        repeat (500) @(negedge clk);
        id = 16'h7084;
        seen_v = 0;
        seen_b = 0;
        repeat (1200) begin
            @(negedge clk);
            if (cfg_valid) seen_v++;
            if (busy) seen_b++;
        end
        chk("t3.novalid", seen_v, 0);
        chk("t3.nobusy", seen_b, 0);
        check_cfg("t3.keep", 16'h7084, 2'd0);

        // Test 4: back-pressure, key change during PUB, then second publish.
        cfg_ready = 1'b0;
        publish("t4a", 16'h4342, 2'd2);
        hold_h = cmos_h_pixel;
        hold_v = cmos_v_pixel;
        hold_a = sdram_max_addr;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cfg_valid !== 1'b1 || cmos_h_pixel !== hold_h ||
                cmos_v_pixel !== hold_v || sdram_max_addr !== hold_a) bad++;
            if (i == 50) begin
                id   = 16'h7016;
                mode = 2'd0;
            end
        end
        chk("t4.hold", bad, 0);
        check_cfg("t4.first", 16'h4342, 2'd2);
        @(negedge clk);
        cfg_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4.ack", 32'(cfg_valid), 0);
        wait_valid("t4b", EXP_LAT + 300, n);
        check_cfg("t4b", 16'h7016, 2'd0);

        // Test 5: abort during the multiply.
        apply_key(16'h1018, 2'd2);
        repeat (1030) @(posedge clk);
        #1;
        chk("t5.mulbusy", 32'(busy), 1);
        apply_key(16'h7084, 2'd1);
        @(posedge clk);
        #1;
        chk("t5.abort", 32'(busy), 0);
        chk("t5.novalid", 32'(cfg_valid), 0);
        wait_valid("t5", EXP_LAT + 300, n);
        chk_lat("t5", n + 1);
        check_cfg("t5", 16'h7084, 2'd1);

        // Test 6: unknown ID, reserved mode.
        publish("t6", 16'h1234, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
